spi_slave_axi_mem: RTL and testbench



---
 rtl/spi_slave_axi_mem.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_slave_axi_mem.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_axi_mem.sv
// spi_slave_axi_mem
// AXI4 slave in front of a single-port on-chip RAM. Serves the bursts that the
// SPI slave bridge issues: FIXED, INCR and WRAP bursts, byte strobes, one
// write and one read burst in flight at a time, SLVERR for out-of-range beats.
//
// Ports
//   axi_aclk, axi_aresetn    clock, asynchronous active-low reset
//   axi_slave_aw_*           write address channel (addr, len, burst, id)
//   axi_slave_w_*            write data channel (data, strb, last)
//   axi_slave_b_*            write response channel (resp, id)
//   axi_slave_ar_*           read address channel (addr, len, burst, id)
//   axi_slave_r_*            read data channel (data, resp, last, id)
module spi_slave_axi_mem #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int MEM_WORDS      = 1024
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          axi_slave_aw_valid,
    output logic                          axi_slave_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_slave_aw_addr,
    input  logic [7:0]                    axi_slave_aw_len,
    input  logic [1:0]                    axi_slave_aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]       axi_slave_aw_id,
    input  logic                          axi_slave_w_valid,
    output logic                          axi_slave_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   axi_slave_w_strb,
    input  logic                          axi_slave_w_last,
    output logic                          axi_slave_b_valid,
    input  logic                          axi_slave_b_ready,
    output logic [1:0]                    axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]       axi_slave_b_id,
    input  logic                          axi_slave_ar_valid,
    output logic                          axi_slave_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_slave_ar_addr,
    input  logic [7:0]                    axi_slave_ar_len,
    input  logic [1:0]                    axi_slave_ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]       axi_slave_ar_id,
    output logic                          axi_slave_r_valid,
    input  logic                          axi_slave_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_slave_r_data,
    output logic [1:0]                    axi_slave_r_resp,
    output logic                          axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]       axi_slave_r_id
);
    localparam int STRB_W     = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int WORD_W     = AXI_ADDR_WIDTH - BYTE_SHIFT;
    localparam int MEM_AW     = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Word index of the beat following 'word'. WRAP keeps the bits above the
    // (len+1)-word window and increments only inside it; non power-of-two
    // wrap lengths degrade to INCR.
    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] word,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [WORD_W-1:0] mask;
        mask = WORD_W'(len);
        case (burst)
            2'b00: next_word = word;
            2'b10: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                    next_word = (word & ~mask) | ((word + WORD_W'(1)) & mask);
                else
                    next_word = word + WORD_W'(1);
            end
            default: next_word = word + WORD_W'(1);
        endcase
    endfunction

    // A beat is serviceable when the burst type is legal and the word exists.
    function automatic logic beat_ok(input logic [WORD_W-1:0] word, input logic [1:0] burst);
        beat_ok = (burst != 2'b11) && (word[WORD_W-1:MEM_AW] == '0);
    endfunction

    // Write channel state
    w_state_t                w_state_reg;
    logic [WORD_W-1:0]       wr_word_reg;
    logic [7:0]              wr_len_reg, wr_cnt_reg;
    logic [1:0]              wr_burst_reg;
    logic                    wr_err_reg;
    logic                    aw_ready_reg, w_ready_reg, b_valid_reg;
    logic [1:0]              b_resp_reg;
    logic [AXI_ID_WIDTH-1:0] b_id_reg;

    // Read channel state
    r_state_t                r_state_reg;
    logic [WORD_W-1:0]       rd_word_reg;
    logic [7:0]              rd_len_reg, rd_cnt_reg;
    logic [1:0]              rd_burst_reg;
    logic                    rd_fetch_left_reg;
    logic                    ar_ready_reg, r_valid_reg, r_last_reg, r_err_reg;
    logic [AXI_ID_WIDTH-1:0] r_id_reg;

    // RAM
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [AXI_DATA_WIDTH-1:0] ram_rdata_reg;
    logic [MEM_AW-1:0]         ram_addr;
    logic                      ram_we, ram_re;

    logic w_fire, wr_beat_ok, wr_is_last, wr_err_next;
    logic rd_fetch, rd_beat_ok;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{axi_slave_aw_addr[BYTE_SHIFT-1:0], axi_slave_ar_addr[BYTE_SHIFT-1:0]};

    always_comb begin
        w_fire      = axi_slave_w_valid & w_ready_reg;
        wr_beat_ok  = beat_ok(wr_word_reg, wr_burst_reg);
        wr_is_last  = (wr_cnt_reg == wr_len_reg);
        wr_err_next = wr_err_reg | ~wr_beat_ok | (axi_slave_w_last != wr_is_last);
        ram_we      = w_fire & wr_beat_ok;
        rd_beat_ok  = beat_ok(rd_word_reg, rd_burst_reg);
        // A read beat is fetched only when the output register will be free
        // at the next edge, and never in a cycle that carries a write beat.
        rd_fetch    = (r_state_reg == R_DATA) & rd_fetch_left_reg
                      & (~r_valid_reg | axi_slave_r_ready) & ~w_fire;
        ram_re      = rd_fetch & rd_beat_ok;
        ram_addr    = ram_we ? wr_word_reg[MEM_AW-1:0] : rd_word_reg[MEM_AW-1:0];
    end

    // Contents are not reset; the read register only moves on a fetch so the
    // presented beat stays stable under backpressure.
    always_ff @(posedge axi_aclk) begin
        if (ram_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_slave_w_strb[i])
                    mem[ram_addr][i*8 +: 8] <= axi_slave_w_data[i*8 +: 8];
            end
        end
        if (ram_re)
            ram_rdata_reg <= mem[ram_addr];
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_reg  <= W_IDLE;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= 2'b00;
            b_id_reg     <= '0;
            wr_word_reg  <= '0;
            wr_len_reg   <= '0;
            wr_cnt_reg   <= '0;
            wr_burst_reg <= 2'b00;
            wr_err_reg   <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    aw_ready_reg <= 1'b1;
                    if (axi_slave_aw_valid && aw_ready_reg) begin
                        aw_ready_reg <= 1'b0;
                        w_ready_reg  <= 1'b1;
                        wr_word_reg  <= axi_slave_aw_addr[AXI_ADDR_WIDTH-1:BYTE_SHIFT];
                        wr_len_reg   <= axi_slave_aw_len;
                        wr_burst_reg <= axi_slave_aw_burst;
                        b_id_reg     <= axi_slave_aw_id;
                        wr_cnt_reg   <= '0;
                        wr_err_reg   <= 1'b0;
                        w_state_reg  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (wr_is_last) begin
                            w_ready_reg <= 1'b0;
                            b_valid_reg <= 1'b1;
                            b_resp_reg  <= wr_err_next ? 2'b10 : 2'b00;
                            w_state_reg <= W_RESP;
                        end else begin
                            wr_cnt_reg  <= wr_cnt_reg + 8'd1;
                            wr_word_reg <= next_word(wr_word_reg, wr_len_reg, wr_burst_reg);
                            wr_err_reg  <= wr_err_next;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_slave_b_ready) begin
                        b_valid_reg  <= 1'b0;
                        aw_ready_reg <= 1'b1;
                        w_state_reg  <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_reg       <= R_IDLE;
            ar_ready_reg      <= 1'b0;
            r_valid_reg       <= 1'b0;
            r_last_reg        <= 1'b0;
            r_err_reg         <= 1'b0;
            r_id_reg          <= '0;
            rd_word_reg       <= '0;
            rd_len_reg        <= '0;
            rd_cnt_reg        <= '0;
            rd_burst_reg      <= 2'b00;
            rd_fetch_left_reg <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    ar_ready_reg <= 1'b1;
                    if (axi_slave_ar_valid && ar_ready_reg) begin
                        ar_ready_reg      <= 1'b0;
                        rd_word_reg       <= axi_slave_ar_addr[AXI_ADDR_WIDTH-1:BYTE_SHIFT];
                        rd_len_reg        <= axi_slave_ar_len;
                        rd_burst_reg      <= axi_slave_ar_burst;
                        r_id_reg          <= axi_slave_ar_id;
                        rd_cnt_reg        <= '0;
                        rd_fetch_left_reg <= 1'b1;
                        r_state_reg       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rd_fetch) begin
                        r_valid_reg <= 1'b1;
                        r_last_reg  <= (rd_cnt_reg == rd_len_reg);
                        r_err_reg   <= ~rd_beat_ok;
                        if (rd_cnt_reg == rd_len_reg) begin
                            rd_fetch_left_reg <= 1'b0;
                        end else begin
                            rd_cnt_reg  <= rd_cnt_reg + 8'd1;
                            rd_word_reg <= next_word(rd_word_reg, rd_len_reg, rd_burst_reg);
                        end
                    end else if (r_valid_reg && axi_slave_r_ready) begin
                        r_valid_reg <= 1'b0;
                        r_last_reg  <= 1'b0;
                        r_err_reg   <= 1'b0;
                    end
                    if (r_valid_reg && axi_slave_r_ready && r_last_reg) begin
                        ar_ready_reg <= 1'b1;
                        r_state_reg  <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign axi_slave_aw_ready = aw_ready_reg;
    assign axi_slave_w_ready  = w_ready_reg;
    assign axi_slave_b_valid  = b_valid_reg;
    assign axi_slave_b_resp   = b_resp_reg;
    assign axi_slave_b_id     = b_id_reg;
    assign axi_slave_ar_ready = ar_ready_reg;
    assign axi_slave_r_valid  = r_valid_reg;
    assign axi_slave_r_last   = r_last_reg;
    assign axi_slave_r_resp   = {r_err_reg, 1'b0};
    assign axi_slave_r_id     = r_id_reg;
    // Error beats and idle cycles present zero data.
    assign axi_slave_r_data   = (r_valid_reg && !r_err_reg) ? ram_rdata_reg : '0;

endmodule

// File: tb/tb_spi_slave_axi_mem.sv
// Testbench for spi_slave_axi_mem: directed and random bursts checked against
// a word-array reference model that computes beat addresses arithmetically.
module tb_spi_slave_axi_mem;
    localparam int AW = 32, DW = 64, IW = 3, MW = 1024, SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          aw_valid = 0, aw_ready;
    logic [AW-1:0] aw_addr = '0;
    logic [7:0]    aw_len = '0;
    logic [1:0]    aw_burst = '0;
    logic [IW-1:0] aw_id = '0;
    logic          w_valid = 0, w_ready, w_last = 0;
    logic [DW-1:0] w_data = '0;
    logic [SW-1:0] w_strb = '0;
    logic          b_valid, b_ready = 0;
    logic [1:0]    b_resp;
    logic [IW-1:0] b_id;
    logic          ar_valid = 0, ar_ready;
    logic [AW-1:0] ar_addr = '0;
    logic [7:0]    ar_len = '0;
    logic [1:0]    ar_burst = '0;
    logic [IW-1:0] ar_id = '0;
    logic          r_valid, r_ready = 0, r_last;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic [IW-1:0] r_id;

    spi_slave_axi_mem #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MEM_WORDS(MW)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .axi_slave_aw_valid(aw_valid), .axi_slave_aw_ready(aw_ready), .axi_slave_aw_addr(aw_addr),
        .axi_slave_aw_len(aw_len), .axi_slave_aw_burst(aw_burst), .axi_slave_aw_id(aw_id),
        .axi_slave_w_valid(w_valid), .axi_slave_w_ready(w_ready), .axi_slave_w_data(w_data),
        .axi_slave_w_strb(w_strb), .axi_slave_w_last(w_last),
        .axi_slave_b_valid(b_valid), .axi_slave_b_ready(b_ready), .axi_slave_b_resp(b_resp), .axi_slave_b_id(b_id),
        .axi_slave_ar_valid(ar_valid), .axi_slave_ar_ready(ar_ready), .axi_slave_ar_addr(ar_addr),
        .axi_slave_ar_len(ar_len), .axi_slave_ar_burst(ar_burst), .axi_slave_ar_id(ar_id),
        .axi_slave_r_valid(r_valid), .axi_slave_r_ready(r_ready), .axi_slave_r_data(r_data),
        .axi_slave_r_resp(r_resp), .axi_slave_r_last(r_last), .axi_slave_r_id(r_id)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] model_mem [MW];
    logic [DW-1:0] wbuf [16];
    logic [SW-1:0] sbuf [16];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word touched by beat k: FIXED repeats, INCR counts up, WRAP rotates
    // inside the aligned window of len+1 words (only for 2/4/8/16 beats).
    function automatic longint beat_word(input logic [AW-1:0] addr, input int len,
                                         input logic [1:0] burst, input int k);
        longint start, n, base;
        start = longint'(addr >> 3);
        n = longint'(len + 1);
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            base = (start / n) * n;
            return base + (start - base + longint'(k)) % n;
        end
        return start + longint'(k);
    endfunction

    function automatic bit beat_ok(input longint w, input logic [1:0] burst);
        return (burst != 2'b11) && (w < longint'(MW));
    endfunction

    task automatic fill(input bit full_strb);
        for (int k = 0; k < 16; k++) begin
            wbuf[k] = {$urandom, $urandom};
            sbuf[k] = full_strb ? '1 : SW'($urandom);
        end
    endtask

    task automatic apply_reset();
        rst_n = 0;
        aw_valid = 0; w_valid = 0; w_last = 0; ar_valid = 0; b_ready = 0; r_ready = 0;
        #1;
        check("rst_aw_ready", aw_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_ar_ready", ar_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_b_resp", b_resp, 0);
        check("rst_r_resp", r_resp, 0);
        check("rst_r_data", r_data, 0);
        check("rst_b_id", b_id, 0);
        check("rst_r_id", r_id, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        check("aw_ready_rise", aw_ready, 1);
        check("ar_ready_rise", ar_ready, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input int bad_last_at, input int abort_after);
        int cyc;
        longint w;
        bit exp_err;
        exp_err = (bad_last_at >= 0 && bad_last_at <= len);
        aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_id = id; aw_valid = 1;
        cyc = 0;
        while (aw_ready !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("aw_ready", aw_ready, 1);
        @(posedge clk); #1;
        aw_valid = 0;
        for (int k = 0; k <= len; k++) begin
            w = beat_word(addr, len, burst, k);
            w_data = wbuf[k]; w_strb = sbuf[k];
            w_last = (k == len) ^ (k == bad_last_at);
            w_valid = 1;
            cyc = 0;
            while (w_ready !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
            check("w_ready", w_ready, 1);
            @(posedge clk); #1;
            if (beat_ok(w, burst)) begin
                for (int b = 0; b < SW; b++)
                    if (sbuf[k][b]) model_mem[int'(w)][b*8 +: 8] = wbuf[k][b*8 +: 8];
            end else begin
                exp_err = 1;
            end
            if (k == abort_after) begin
                apply_reset();
                return;
            end
        end
        w_valid = 0; w_last = 0;
        check("b_valid_timing", b_valid, 1);
        b_ready = 1;
        cyc = 0;
        while (b_valid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("b_resp", b_resp, exp_err ? 2 : 0);
        check("b_id", b_id, id);
        @(posedge clk); #1;
        b_ready = 0;
        $display("write addr=%h len=%0d burst=%0d id=%0d resp=%0d", addr, len, burst, id, b_resp);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                           input logic [IW-1:0] id, input bit toggle, input bit check_lat);
        int cyc, lat, k;
        longint w;
        bit seen, ok;
        logic [DW-1:0] exp_d;
        ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_id = id; ar_valid = 1;
        cyc = 0;
        while (ar_ready !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("ar_ready", ar_ready, 1);
        @(posedge clk); #1;
        ar_valid = 0;
        lat = 1; k = 0; cyc = 0; seen = 0;
        while (k <= len && cyc < 400) begin
            r_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (r_valid === 1'b1) begin
                if (!seen && check_lat) check("r_latency", lat, 2);
                seen = 1;
                w = beat_word(addr, len, burst, k);
                ok = beat_ok(w, burst);
                exp_d = ok ? model_mem[int'(w)] : '0;
                check("r_data", r_data, exp_d);
                check("r_resp", r_resp, ok ? 0 : 2);
                check("r_last", r_last, (k == len));
                check("r_id", r_id, id);
                if (r_ready) k++;
            end
            @(posedge clk); #1;
            cyc++; lat++;
        end
        r_ready = 0;
        check("r_beats", k, len + 1);
        check("ar_ready_back", ar_ready, 1);
        $display("read  addr=%h len=%0d burst=%0d id=%0d beats=%0d", addr, len, burst, id, k);
    endtask

    initial begin
        logic [AW-1:0] a;
        int l;
        logic [1:0] bt;
        #2;
        apply_reset();

        // Give every word a defined value so partial strobes are predictable.
        for (int i = 0; i < MW / 16; i++) begin
            fill(1);
            do_write(AW'(i * 128), 15, 2'b01, 3'd0, -1, -1);
        end

        // INCR write then read
        for (int k = 0; k < 4; k++) begin wbuf[k] = DW'(8'hA0 + k); sbuf[k] = '1; end
        do_write(32'h10, 3, 2'b01, 3'd5, -1, -1);
        do_read(32'h10, 3, 2'b01, 3'd6, 0, 1);

        // WRAP read
        for (int k = 0; k < 4; k++) begin wbuf[k] = DW'(8'hB0 + k); sbuf[k] = '1; end
        do_write(32'h0, 3, 2'b01, 3'd1, -1, -1);
        do_read(32'h18, 3, 2'b10, 3'd2, 0, 1);

        // Byte strobes
        wbuf[0] = '1; sbuf[0] = '1;
        do_write(32'h28, 0, 2'b01, 3'd3, -1, -1);
        wbuf[0] = '0; sbuf[0] = 8'h0F;
        do_write(32'h28, 0, 2'b01, 3'd3, -1, -1);
        do_read(32'h28, 0, 2'b01, 3'd4, 0, 1);

        // Out-of-range second beat
        fill(1);
        do_write(AW'((MW - 1) * 8), 1, 2'b01, 3'd3, -1, -1);
        do_read(AW'((MW - 1) * 8), 1, 2'b01, 3'd4, 1, 1);

        // FIXED with partial strobes, reserved burst type, odd-length WRAP, long WRAP
        fill(0);
        do_write(32'h38, 2, 2'b00, 3'd7, -1, -1);
        do_read(32'h38, 2, 2'b00, 3'd7, 0, 1);
        fill(1);
        do_write(32'h80, 1, 2'b11, 3'd2, -1, -1);
        do_read(32'h80, 1, 2'b11, 3'd2, 0, 1);
        fill(1);
        do_write(32'h1A8, 2, 2'b10, 3'd1, -1, -1);
        do_read(32'h1A8, 2, 2'b10, 3'd1, 1, 1);
        fill(0);
        do_write(32'h2E8, 7, 2'b10, 3'd6, -1, -1);
        do_read(32'h2E8, 7, 2'b10, 3'd5, 0, 1);

        // w_last early: data still written, response SLVERR
        fill(1);
        do_write(32'h400, 1, 2'b01, 3'd2, 0, -1);
        do_read(32'h400, 1, 2'b01, 3'd2, 0, 1);

        // Concurrent 16-beat write and read with read backpressure
        fill(1);
        do_write(AW'(200 * 8), 15, 2'b01, 3'd1, -1, -1);
        fill(1);
        fork
            do_write(AW'(100 * 8), 15, 2'b01, 3'd7, -1, -1);
            do_read(AW'(200 * 8), 15, 2'b01, 3'd2, 1, 0);
        join
        do_read(AW'(100 * 8), 15, 2'b01, 3'd3, 0, 1);

        // Reset after beat 2 of 4, then normal traffic
        fill(1);
        do_write(AW'(300 * 8), 3, 2'b01, 3'd4, -1, 1);
        fill(1);
        do_write(AW'(300 * 8), 3, 2'b01, 3'd5, -1, -1);
        do_read(AW'(300 * 8), 3, 2'b01, 3'd6, 0, 1);

        // Random bursts
        for (int t = 0; t < 12; t++) begin
            l  = int'($urandom_range(0, 15));
            bt = 2'($urandom_range(0, 2));
            a  = AW'($urandom_range(0, MW - 20) * 8 + $urandom_range(0, 7));
            fill(0);
            do_write(a, l, bt, IW'($urandom), -1, -1);
            do_read(a, l, bt, IW'($urandom), 1'($urandom), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
